// File: rtl/alu_issuer_if.sv
// rtl/alu_issuer_if.sv - command, ALU-side and response signal bundle for alu_issuer
interface alu_issuer_if #(
    parameter int INT_W  = 3,
    parameter int FRAC_W = 5,
    parameter int INST_W = 3,
    parameter int DATA_W = INT_W + FRAC_W,
    parameter int TAG_W  = 4
);
    // command stream into the issuer
    logic              i_cmd_valid;
    logic              o_cmd_ready;
    logic [DATA_W-1:0] i_cmd_a;
    logic [DATA_W-1:0] i_cmd_b;
    logic [INST_W-1:0] i_cmd_inst;

    // issue port toward the ALU and its result
    logic              o_alu_valid;
    logic [DATA_W-1:0] o_alu_a;
    logic [DATA_W-1:0] o_alu_b;
    logic [INST_W-1:0] o_alu_inst;
    logic              i_alu_valid;
    logic [DATA_W-1:0] i_alu_data;

    // response stream out of the issuer
    logic              o_rsp_valid;
    logic              i_rsp_ready;
    logic [DATA_W-1:0] o_rsp_data;
    logic [INST_W-1:0] o_rsp_inst;
    logic [TAG_W-1:0]  o_rsp_tag;

    // status
    logic              o_busy;
    logic              o_err;

    modport master (
        input  i_cmd_valid, i_cmd_a, i_cmd_b, i_cmd_inst,
        output o_cmd_ready,
        output o_alu_valid, o_alu_a, o_alu_b, o_alu_inst,
        input  i_alu_valid, i_alu_data,
        output o_rsp_valid, o_rsp_data, o_rsp_inst, o_rsp_tag,
        input  i_rsp_ready,
        output o_busy, o_err
    );

    modport slave (
        output i_cmd_valid, i_cmd_a, i_cmd_b, i_cmd_inst,
        input  o_cmd_ready,
        input  o_alu_valid, o_alu_a, o_alu_b, o_alu_inst,
        output i_alu_valid, i_alu_data,
        input  o_rsp_valid, o_rsp_data, o_rsp_inst, o_rsp_tag,
        output i_rsp_ready,
        input  o_busy, o_err
    );
endinterface

// File: rtl/alu_issuer.sv
// rtl/alu_issuer.sv - FIFO-buffered command issuer for the fixed-point alu (optional missing-result detection: ALU_ISSUER_ERR_EN)
module alu_issuer #(
    parameter int INT_W  = 3,
    parameter int FRAC_W = 5,
    parameter int INST_W = 3,
    parameter int DATA_W = INT_W + FRAC_W,
    parameter int DEPTH  = 4,
    parameter int TAG_W  = 4
) (
    input  logic          i_clk,
    input  logic          i_rst,
    alu_issuer_if.master  bus
);
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = 2 * DATA_W + INST_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [ENTRY_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [TAG_W-1:0]   tag_cnt_q, tag_cnt_d;
    logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;
    logic [INST_W-1:0]  rsp_inst_q, rsp_inst_d;
    logic [TAG_W-1:0]   rsp_tag_q, rsp_tag_d;
`ifdef ALU_ISSUER_ERR_EN
    logic               err_q, err_d;
`endif

    logic               full;
    logic               push;
    logic               pop;
    logic [DATA_W-1:0]  head_a;
    logic [DATA_W-1:0]  head_b;
    logic [INST_W-1:0]  head_inst;
    logic               in_issue;

    // ready depends only on the registered count, never on i_cmd_valid
    assign full     = (count_q == CNT_W'(DEPTH));
    assign push     = bus.i_cmd_valid && !full;
    // the FSM only enters ISSUE with a non-empty FIFO, so the pop is always legal
    assign pop      = (state_q == ST_ISSUE);
    assign in_issue = (state_q == ST_ISSUE);
    assign {head_a, head_b, head_inst} = mem_q[rd_ptr_q];

    // FIFO storage, pointers and occupancy for the next cycle
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = {bus.i_cmd_a, bus.i_cmd_b, bus.i_cmd_inst};
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // issue sequencing: next state, tag allocation and response capture
    always_comb begin
        state_d    = state_q;
        tag_cnt_d  = tag_cnt_q;
        rsp_data_d = rsp_data_q;
        rsp_inst_d = rsp_inst_q;
        rsp_tag_d  = rsp_tag_q;
`ifdef ALU_ISSUER_ERR_EN
        err_d      = err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (count_q != '0) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                rsp_inst_d = head_inst;
                rsp_tag_d  = tag_cnt_q;
                tag_cnt_d  = tag_cnt_q + 1'b1;
                state_d    = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.i_alu_valid) begin
                    rsp_data_d = bus.i_alu_data;
                    state_d    = ST_HOLD;
                end else begin
`ifdef ALU_ISSUER_ERR_EN
                    // the ALU has fixed 1-cycle latency; no result means it is lost
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
`endif
                end
            end
            ST_HOLD: begin
                if (bus.i_rsp_ready) begin
                    // count_d includes a same-cycle push so it is not missed
                    state_d = (count_d != '0) ? ST_ISSUE : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // state register; reset discards queued and in-flight commands
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= ST_IDLE;
            mem_q      <= '{default: '0};
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            tag_cnt_q  <= '0;
            rsp_data_q <= '0;
            rsp_inst_q <= '0;
            rsp_tag_q  <= '0;
        end else begin
            state_q    <= state_d;
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            tag_cnt_q  <= tag_cnt_d;
            rsp_data_q <= rsp_data_d;
            rsp_inst_q <= rsp_inst_d;
            rsp_tag_q  <= rsp_tag_d;
        end
    end

`ifdef ALU_ISSUER_ERR_EN
    // sticky missing-result flag, cleared only by reset
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
    assign bus.o_err = err_q;
`else
    assign bus.o_err = 1'b0;
`endif

    assign bus.o_cmd_ready = !full;
    assign bus.o_alu_valid = in_issue;
    assign bus.o_alu_a     = in_issue ? head_a    : '0;
    assign bus.o_alu_b     = in_issue ? head_b    : '0;
    assign bus.o_alu_inst  = in_issue ? head_inst : '0;
    assign bus.o_rsp_valid = (state_q == ST_HOLD);
    assign bus.o_rsp_data  = rsp_data_q;
    assign bus.o_rsp_inst  = rsp_inst_q;
    assign bus.o_rsp_tag   = rsp_tag_q;
    assign bus.o_busy      = (count_q != '0) || (state_q != ST_IDLE);
endmodule
